// File: rtl/dbg_printf_arbiter.sv
// dbg_printf_arbiter
// Collects printf messages from up to NUM_CH debug sources, buffers one
// message per channel, picks the next channel round-robin and serialises
// the message MSB byte first onto the uart_tx valid/ready byte interface.
// An optional ASCII tag byte ('0' + channel) can be sent before each message.
//
// Ports:
//   clk_i         system clock
//   rst_i         asynchronous active-high reset
//   ch_data_i     channel c message at [c*DATA_NUM*8 +: DATA_NUM*8]
//   ch_printf_i   per-channel request, rising edge captures the message
//   clear_i       synchronous clear of overflow_o
//   tx_ready_i    uart_tx ready for a byte
//   tx_data_o     byte to uart_tx (registered)
//   tx_valid_o    byte valid to uart_tx (registered)
//   ch_pending_o  message buffered and not yet granted
//   overflow_o    sticky: capture arrived while the channel was pending
//   busy_o        a message is being sent
module dbg_printf_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int DATA_NUM  = 4,
  parameter int PREFIX_EN = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_CH*DATA_NUM*8-1:0] ch_data_i,
  input  logic [NUM_CH-1:0]          ch_printf_i,
  input  logic                       clear_i,
  input  logic                       tx_ready_i,
  output logic [7:0]                 tx_data_o,
  output logic                       tx_valid_o,
  output logic [NUM_CH-1:0]          ch_pending_o,
  output logic [NUM_CH-1:0]          overflow_o,
  output logic                       busy_o
);

  localparam int MSG_W = DATA_NUM * 8;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(DATA_NUM + 1);

  typedef enum logic [1:0] {S_IDLE, S_PREFIX, S_DATA} state_t;

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   printf_p1;
  logic [NUM_CH-1:0]   pending_q;
  logic [NUM_CH-1:0]   overflow_q;
  logic [NUM_CH-1:0]   rise;
  logic [NUM_CH-1:0]   gnt_oh;
  logic [NUM_CH-1:0]   cap_ok;
  logic [NUM_CH-1:0]   ovf_set;
  logic [CH_W-1:0]     last_grant_q;
  logic [CH_W-1:0]     gnt_idx;
  logic [CH_W-1:0]     search_idx;
  logic                gnt_vld;
  logic [MSG_W-1:0]    msg_buf [NUM_CH];
  logic [MSG_W-1:0]    shreg_q, shreg_d, shreg_sh;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          tx_data_d;
  logic                tx_valid_d;
  logic                xfer;
  logic                last_byte;

  assign xfer      = tx_valid_o & tx_ready_i;
  assign last_byte = (cnt_q == CNT_W'(DATA_NUM - 1));
  assign shreg_sh  = shreg_q << 8;

  // ---- capture stage: edge detect against the registered request ----
  assign rise = ch_printf_i & ~printf_p1;
  // A channel being granted this cycle frees its buffer, so a new edge on
  // it is accepted rather than counted as an overflow.
  assign cap_ok  = rise & (~pending_q | gnt_oh);
  assign ovf_set = rise & pending_q & ~gnt_oh;

  // ---- arbitration: first pending channel after last_grant, wrapping ----
  always_comb begin
    gnt_vld    = 1'b0;
    gnt_idx    = last_grant_q;
    gnt_oh     = '0;
    search_idx = last_grant_q;
    if (state_q == S_IDLE) begin
      for (int i = 0; i < NUM_CH; i++) begin
        search_idx = (search_idx == CH_W'(NUM_CH - 1)) ? '0 : search_idx + 1'b1;
        if (!gnt_vld && pending_q[search_idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = search_idx;
        end
      end
    end
    if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
  end

  // ---- FSM state register ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---- FSM next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (gnt_vld) state_d = (PREFIX_EN != 0) ? S_PREFIX : S_DATA;
      S_PREFIX: if (xfer) state_d = S_DATA;
      S_DATA:   if (xfer && last_byte) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---- FSM outputs: next values of the registered byte stream ----
  always_comb begin
    tx_valid_d = tx_valid_o;
    tx_data_d  = tx_data_o;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          tx_valid_d = 1'b1;
          cnt_d      = '0;
          shreg_d    = msg_buf[gnt_idx];
          tx_data_d  = (PREFIX_EN != 0) ? 8'h30 + 8'(gnt_idx)
                                        : msg_buf[gnt_idx][MSG_W-1 -: 8];
        end
      end
      S_PREFIX: begin
        if (xfer) tx_data_d = shreg_q[MSG_W-1 -: 8];
      end
      S_DATA: begin
        // The byte on the wire is always the top of the shift register.
        if (xfer) begin
          if (last_byte) begin
            tx_valid_d = 1'b0;
          end else begin
            cnt_d     = cnt_q + 1'b1;
            shreg_d   = shreg_sh;
            tx_data_d = shreg_sh[MSG_W-1 -: 8];
          end
        end
      end
      default: tx_valid_d = 1'b0;
    endcase
  end

  // ---- control registers ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      printf_p1    <= '0;
      pending_q    <= '0;
      overflow_q   <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      cnt_q        <= '0;
      tx_valid_o   <= 1'b0;
      tx_data_o    <= 8'h00;
    end else begin
      printf_p1  <= ch_printf_i;
      pending_q  <= (pending_q & ~gnt_oh) | cap_ok;
      // A new overflow in the same cycle as clear_i still sets the flag.
      overflow_q <= (clear_i ? '0 : overflow_q) | ovf_set;
      if (gnt_vld) last_grant_q <= gnt_idx;
      cnt_q      <= cnt_d;
      tx_valid_o <= tx_valid_d;
      tx_data_o  <= tx_data_d;
    end
  end

  // ---- data registers: message buffers and shift register ----
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (cap_ok[c]) msg_buf[c] <= ch_data_i[c*MSG_W +: MSG_W];
    end
    shreg_q <= shreg_d;
  end

  assign ch_pending_o = pending_q;
  assign overflow_o   = overflow_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_dbg_printf_arbiter.sv
module tb_dbg_printf_arbiter;

  localparam int NUM_CH   = 4;
  localparam int DATA_NUM = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] ch_data = '0;
  logic [3:0]   ch_printf = '0;
  logic         clear = 1'b0;
  logic         tx_ready = 1'b0;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic [3:0]   pend;
  logic [3:0]   ovf;
  logic         busy;

  logic [127:0] d2_data = '0;
  logic [3:0]   d2_printf = '0;
  logic         d2_clear = 1'b0;
  logic         d2_ready = 1'b1;
  logic [7:0]   d2_tx_data;
  logic         d2_valid;
  logic [3:0]   d2_pend;
  logic [3:0]   d2_ovf;
  logic         d2_busy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp2_q[$];

  dbg_printf_arbiter #(.NUM_CH(NUM_CH), .DATA_NUM(DATA_NUM), .PREFIX_EN(1)) dut (
    .clk_i(clk), .rst_i(rst), .ch_data_i(ch_data), .ch_printf_i(ch_printf),
    .clear_i(clear), .tx_ready_i(tx_ready), .tx_data_o(tx_data),
    .tx_valid_o(tx_valid), .ch_pending_o(pend), .overflow_o(ovf), .busy_o(busy)
  );

  dbg_printf_arbiter #(.NUM_CH(NUM_CH), .DATA_NUM(DATA_NUM), .PREFIX_EN(0)) dut_np (
    .clk_i(clk), .rst_i(rst), .ch_data_i(d2_data), .ch_printf_i(d2_printf),
    .clear_i(d2_clear), .tx_ready_i(d2_ready), .tx_data_o(d2_tx_data),
    .tx_valid_o(d2_valid), .ch_pending_o(d2_pend), .overflow_o(d2_ovf), .busy_o(d2_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int c, input logic [31:0] d);
    ch_data[c*32 +: 32] = d;
  endtask

  task automatic push_msg(input int c, input logic [31:0] d);
    logic [7:0] tag;
    tag = 8'(8'h30 + c);
    exp_q.push_back(tag);
    exp_q.push_back(d[31:24]);
    exp_q.push_back(d[23:16]);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
  endtask

  task automatic pulse(input logic [3:0] mask);
    ch_printf = mask;
    tick();
    ch_printf = '0;
    tick();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || pend != 0 || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL %s: still busy after %0d cycles, %0d bytes outstanding", name, n, exp_q.size());
    end
  endtask

  // Scoreboard monitors: a byte transfers on the next rising edge.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL tx_byte: got unexpected %h, required none", tx_data);
      end else begin
        chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && d2_valid && d2_ready) begin
      if (exp2_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL np_tx_byte: got unexpected %h, required none", d2_tx_data);
      end else begin
        chk("np_tx_byte", {24'h0, d2_tx_data}, {24'h0, exp2_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    tick(2);
    chk("rst_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_data", {24'h0, tx_data}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_pend", {28'h0, pend}, 32'h0);
    chk("rst_ovf", {28'h0, ovf}, 32'h0);
    rst = 1'b0;
    tick();

    // Single message with tag on ch1
    tx_ready = 1'b1;
    set_data(1, 32'h41424344);
    push_msg(1, 32'h41424344);
    pulse(4'b0010);
    chk("t1_pend_after_grant", {28'h0, pend}, 32'h0);
    chk("t1_busy", {31'h0, busy}, 32'h1);
    chk("t1_first_byte", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'h31});
    tick(4);
    chk("t1_last_byte", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'h44});
    tick();
    chk("t1_valid_drop", {31'h0, tx_valid}, 32'h0);
    chk("t1_busy_drop", {31'h0, busy}, 32'h0);

    // Backpressure mid-message on ch2
    set_data(2, 32'h10203040);
    push_msg(2, 32'h10203040);
    pulse(4'b0100);
    tick(2);
    chk("t3_before_stall", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'h20});
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_stall_hold", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'h20});
    end
    tx_ready = 1'b1;
    wait_idle("t3_drain", 50);

    // Overflow on ch2 while ch1 transmits
    tx_ready = 1'b0;
    set_data(1, 32'h51525354);
    push_msg(1, 32'h51525354);
    pulse(4'b0010);
    set_data(2, 32'h61626364);
    push_msg(2, 32'h61626364);
    pulse(4'b0100);
    chk("t4_pend", {28'h0, pend}, 32'h4);
    set_data(2, 32'hEEEEEEEE);
    pulse(4'b0100);
    chk("t4_ovf_set", {28'h0, ovf}, 32'h4);
    chk("t4_pend_kept", {28'h0, pend}, 32'h4);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t4_ovf_clear", {28'h0, ovf}, 32'h0);
    clear = 1'b1;
    ch_printf = 4'b0100;
    tick();
    clear = 1'b0;
    ch_printf = '0;
    tick();
    chk("t4_ovf_set_wins", {28'h0, ovf}, 32'h4);
    tx_ready = 1'b1;
    wait_idle("t4_drain", 80);
    chk("t4_ovf_sticky", {28'h0, ovf}, 32'h4);

    // Recapture on ch1 in its grant cycle
    tx_ready = 1'b0;
    set_data(0, 32'h90919293);
    push_msg(0, 32'h90919293);
    pulse(4'b0001);
    set_data(1, 32'h71727374);
    push_msg(1, 32'h71727374);
    pulse(4'b0010);
    tx_ready = 1'b1;
    tick(5);
    chk("t5_ch0_done", {31'h0, tx_valid}, 32'h0);
    set_data(1, 32'h81828384);
    push_msg(1, 32'h81828384);
    ch_printf = 4'b0010;
    tick();
    ch_printf = '0;
    chk("t5_pend_kept", {28'h0, pend}, 32'h2);
    chk("t5_busy", {31'h0, busy}, 32'h1);
    chk("t5_no_ovf", {28'h0, ovf}, 32'h4);
    wait_idle("t5_drain", 80);

    // Reset during byte 2 of a ch3 message
    set_data(3, 32'hF1F2F3F4);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'hF1);
    exp_q.push_back(8'hF2);
    pulse(4'b1000);
    tick(3);
    chk("t6_byte2", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'hF3});
    rst = 1'b1;
    #1;
    chk("t6_async_valid", {31'h0, tx_valid}, 32'h0);
    chk("t6_async_data", {24'h0, tx_data}, 32'h0);
    chk("t6_async_busy", {31'h0, busy}, 32'h0);
    chk("t6_async_pend", {28'h0, pend}, 32'h0);
    chk("t6_async_ovf", {28'h0, ovf}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("t6_pre_reset_bytes", exp_q.size(), 32'h0);

    // Simultaneous requests after reset: ch0 first
    set_data(0, 32'hA0A1A2A3);
    set_data(2, 32'hB0B1B2B3);
    set_data(3, 32'hD0D1D2D3);
    push_msg(0, 32'hA0A1A2A3);
    push_msg(2, 32'hB0B1B2B3);
    push_msg(3, 32'hD0D1D2D3);
    pulse(4'b1101);
    wait_idle("t2_drain", 200);

    // Wrap: last grant ch0, then ch0+ch3 gives ch3 first
    set_data(0, 32'h12345678);
    push_msg(0, 32'h12345678);
    pulse(4'b0001);
    wait_idle("t2_ch0_drain", 60);
    set_data(0, 32'h0F1E2D3C);
    set_data(3, 32'h55AA55AA);
    push_msg(3, 32'h55AA55AA);
    push_msg(0, 32'h0F1E2D3C);
    pulse(4'b1001);
    wait_idle("t2_wrap_drain", 120);

    // No-tag build sends exactly DATA_NUM bytes
    d2_data[2*32 +: 32] = 32'hC1C2C3C4;
    exp2_q.push_back(8'hC1);
    exp2_q.push_back(8'hC2);
    exp2_q.push_back(8'hC3);
    exp2_q.push_back(8'hC4);
    d2_printf = 4'b0100;
    tick();
    d2_printf = '0;
    tick();
    chk("np_first", {23'h0, d2_valid, d2_tx_data}, {23'h0, 1'b1, 8'hC1});
    tick(3);
    chk("np_last", {23'h0, d2_valid, d2_tx_data}, {23'h0, 1'b1, 8'hC4});
    tick();
    chk("np_valid_drop", {31'h0, d2_valid}, 32'h0);
    chk("np_busy_drop", {31'h0, d2_busy}, 32'h0);
    chk("np_all_bytes", exp2_q.size(), 32'h0);
    chk("all_bytes", exp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
